// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, data width.
package mem_access_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } state_e;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    is_misaligned = ((size == SIZE_HALF) && off[0]) ||
                    ((size == SIZE_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response channel from the datapath and word-wide data-memory bus.
interface mem_req_if
  import mem_access_pkg::*;
#(
  parameter int unsigned WORD_ADDR_W = 13
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [1:0]             req_size;
  logic                   req_unsigned;
  logic [WORD_ADDR_W+1:0] req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic                   resp_valid;
  logic [DATA_W-1:0]      resp_rdata;
  logic                   resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface mem_bus_if
  import mem_access_pkg::*;
#(
  parameter int unsigned WORD_ADDR_W = 13
);
  logic                   mem_read;
  logic                   mem_write;
  logic [WORD_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_byte_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module byte_lane_align
  import mem_access_pkg::*;
(
  input  size_e             size_i,
  input  logic [1:0]        off_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfword lane uses only off_i[1], so misaligned halves align down.
  always_comb begin
    byte_lane = word_i[{off_i, 3'b000} +: 8];
    half_lane = word_i[{off_i[1], 4'b0000} +: 16];
    load_o    = '0;
    merge_o   = word_i;
    case (size_i)
      SIZE_BYTE: begin
        load_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
        merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_HALF: begin
        load_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
        merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      SIZE_WORD: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit with read-modify-write for sub-word stores.
// Optional macro MISALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned WORD_ADDR_W = 13,
  parameter int unsigned READ_LAT    = 1
)(
  input  logic      clock,
  input  logic      reset,
  mem_req_if.slave  req,
  mem_bus_if.master mem
);

  localparam int unsigned CNT_W = $clog2(READ_LAT) + 1;

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  size_e                  size_q, size_d;
  logic                   uns_q, uns_d;
  logic                   err_q, err_d;
  logic [WORD_ADDR_W+1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  size_e             req_size;
  logic              req_err;
  logic              wait_done;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] merge_word;

  assign req_size  = size_e'(req.req_size);
  assign wait_done = (cnt_q == CNT_W'(READ_LAT - 1));

`ifdef MISALIGN_CHECK_EN
  assign req_err = (req_size == SIZE_RSVD) || is_misaligned(req_size, req.req_addr[1:0]);
`else
  assign req_err = (req_size == SIZE_RSVD);
`endif

  byte_lane_align u_align (
    .size_i     (size_q),
    .off_i      (addr_q[1:0]),
    .unsigned_i (uns_q),
    .word_i     (rdata_q),
    .wdata_i    (wdata_q),
    .load_o     (load_word),
    .merge_o    (merge_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req.req_valid) begin
          we_d    = req.req_we;
          size_d  = req_size;
          uns_d   = req.req_unsigned;
          err_d   = req_err;
          addr_d  = req.req_addr;
          wdata_d = req.req_wdata;
          if (req_err)                              state_d = S_RESP;
          else if (req.req_we && req_size == SIZE_WORD) state_d = S_WR;
          else                                      state_d = S_RD;
        end
      end
      S_RD: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_done) begin
          rdata_d = mem.mem_rdata;
          state_d = we_q ? S_WR : S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req.req_ready  = (state_q == S_IDLE) && !reset;
    req.resp_valid = (state_q == S_RESP);
    req.resp_err   = (state_q == S_RESP) && err_q;
    req.resp_rdata = (state_q == S_RESP && !we_q && !err_q) ? load_word : '0;
    mem.mem_read   = (state_q == S_RD);
    mem.mem_write  = (state_q == S_WR);
    mem.mem_addr   = addr_q[WORD_ADDR_W+1:2];
    mem.mem_wdata  = (state_q == S_WR) ? merge_word : '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-arithmetic model.
// Expectations follow MISALIGN_CHECK_EN when it is defined for the build.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int unsigned AW = 13;
  localparam int unsigned RL = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_req_if #(.WORD_ADDR_W(AW)) req_bus ();
  mem_bus_if #(.WORD_ADDR_W(AW)) mbus ();

  mem_access_unit #(.WORD_ADDR_W(AW), .READ_LAT(RL)) dut (
    .clock (clk),
    .reset (rst),
    .req   (req_bus),
    .mem   (mbus)
  );

  // 16-word memory; preset goes through a backdoor port of the same process.
  logic [31:0] mem_arr [0:15];
  logic [31:0] ref_mem [0:15];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_idx;
  logic [31:0] bd_val;

  always @(posedge clk) begin
    if (bd_we) mem_arr[bd_idx] <= bd_val;
    else if (mbus.mem_write) mem_arr[mbus.mem_addr[3:0]] <= mbus.mem_wdata;
    if (mbus.mem_read) mbus.mem_rdata <= mem_arr[mbus.mem_addr[3:0]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preset(input int unsigned idx, input logic [31:0] val);
    @(negedge clk);
    bd_we  = 1'b1;
    bd_idx = 4'(idx);
    bd_val = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  logic [31:0] last_rdata, last_wr_data;
  logic        last_err;
  int          last_lat, last_nrd, last_wr_cyc;

  task automatic run_req(input bit we, input logic [1:0] size, input bit uns,
                         input logic [AW+1:0] addr, input logic [31:0] wd);
    int unsigned idx, off, nbytes, base;
    logic [31:0] mask, old_w, new_w, ld;
    bit err, exp_rd, exp_wr;
    int exp_lat, exp_wr_cyc;
    int lat, nrd, nwr, rd_cyc, wr_cyc, busy_ready;
    logic [31:0] rd_addr, wr_addr, wr_data, got_rdata;
    logic got_err;

    idx    = int'(addr >> 2) & 15;
    off    = int'(addr) & 3;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base   = off - (off % nbytes);
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    err    = (size == 2'd3);
`ifdef MISALIGN_CHECK_EN
    err = err || (off % nbytes != 0);
`endif
    old_w = ref_mem[idx];
    ld    = (old_w >> (8 * base)) & mask;
    if (!uns && nbytes < 4 && ld[8 * nbytes - 1]) ld = ld | ~mask;
    new_w = (old_w & ~(mask << (8 * base))) | ((wd & mask) << (8 * base));
    exp_lat    = err ? 1 : we ? ((nbytes == 4) ? 2 : 3 + RL) : 2 + RL;
    exp_rd     = !err && !(we && nbytes == 4);
    exp_wr     = !err && we;
    exp_wr_cyc = (nbytes == 4) ? 1 : 2 + RL;

    @(negedge clk);
    check_eq("ready_idle", 32'(req_bus.req_ready), 32'd1);
    req_bus.req_valid    = 1'b1;
    req_bus.req_we       = we;
    req_bus.req_size     = size;
    req_bus.req_unsigned = uns;
    req_bus.req_addr     = addr;
    req_bus.req_wdata    = wd;
    @(posedge clk);

    lat = 0; nrd = 0; nwr = 0; rd_cyc = 0; wr_cyc = 0; busy_ready = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; got_rdata = '0; got_err = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (mbus.mem_read)  begin nrd++; rd_cyc = cyc; rd_addr = 32'(mbus.mem_addr); end
      if (mbus.mem_write) begin nwr++; wr_cyc = cyc; wr_addr = 32'(mbus.mem_addr); wr_data = mbus.mem_wdata; end
      if (req_bus.req_ready) busy_ready++;
      if (req_bus.resp_valid) begin
        lat = cyc; got_err = req_bus.resp_err; got_rdata = req_bus.resp_rdata;
        break;
      end
      // Junk while busy must be ignored.
      req_bus.req_valid    = 1'b1;
      req_bus.req_we       = 1'($urandom);
      req_bus.req_size     = 2'($urandom);
      req_bus.req_unsigned = 1'($urandom);
      req_bus.req_addr     = (AW+2)'($urandom);
      req_bus.req_wdata    = $urandom;
    end
    req_bus.req_valid = 1'b0;

    if (exp_wr) ref_mem[idx] = new_w;
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("resp_err", 32'(got_err), 32'(err));
    check_eq("resp_rdata", got_rdata, (!we && !err) ? ld : 32'd0);
    check_eq("n_reads", 32'(nrd), 32'(exp_rd));
    check_eq("n_writes", 32'(nwr), 32'(exp_wr));
    check_eq("ready_busy", 32'(busy_ready), 32'd0);
    check_eq("mem_word", mem_arr[idx], ref_mem[idx]);
    if (exp_rd) begin
      check_eq("rd_cycle", 32'(rd_cyc), 32'd1);
      check_eq("rd_addr", rd_addr, 32'(int'(addr >> 2)));
    end
    if (exp_wr) begin
      check_eq("wr_cycle", 32'(wr_cyc), 32'(exp_wr_cyc));
      check_eq("wr_addr", wr_addr, 32'(int'(addr >> 2)));
      check_eq("wr_data", wr_data, new_w);
    end
    last_rdata = got_rdata; last_err = got_err; last_lat = lat;
    last_nrd = nrd; last_wr_cyc = wr_cyc; last_wr_data = wr_data;
  endtask

  task automatic reset_outputs_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(req_bus.req_ready), 32'd0);
    check_eq({tag, "_resp_valid"}, 32'(req_bus.resp_valid), 32'd0);
    check_eq({tag, "_mem_read"}, 32'(mbus.mem_read), 32'd0);
    check_eq({tag, "_mem_write"}, 32'(mbus.mem_write), 32'd0);
  endtask

  initial begin
    int nwr_seen;
    rst = 1'b1;
    req_bus.req_valid = 1'b0; req_bus.req_we = 1'b0; req_bus.req_size = 2'd0;
    req_bus.req_unsigned = 1'b0; req_bus.req_addr = '0; req_bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    reset_outputs_zero("rst");
    check_eq("rst_resp_err", 32'(req_bus.resp_err), 32'd0);
    check_eq("rst_resp_rdata", req_bus.resp_rdata, 32'd0);
    check_eq("rst_mem_addr", 32'(mbus.mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mbus.mem_wdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) preset(i, $urandom);
    preset(5, 32'h8899_AABB);

    run_req(0, 2'd2, 0, 15'h0014, 32'h0);
    check_eq("lw_const", last_rdata, 32'h8899_AABB);
    run_req(0, 2'd0, 0, 15'h0015, 32'h0);
    check_eq("lb_const", last_rdata, 32'hFFFF_FFAA);
    run_req(0, 2'd0, 1, 15'h0015, 32'h0);
    check_eq("lbu_const", last_rdata, 32'h0000_00AA);
    run_req(0, 2'd1, 1, 15'h0016, 32'h0);
    check_eq("lhu_const", last_rdata, 32'h0000_8899);
    run_req(1, 2'd0, 0, 15'h0016, 32'h1234_5677);
    check_eq("sb_wdata_const", last_wr_data, 32'h8877_AABB);
    check_eq("sb_wr_cyc_const", 32'(last_wr_cyc), 32'd3);
    check_eq("sb_lat_const", 32'(last_lat), 32'd4);
    run_req(0, 2'd2, 0, 15'h0014, 32'h0);
    check_eq("lw_after_sb", last_rdata, 32'h8877_AABB);
    run_req(1, 2'd2, 0, 15'h0014, 32'hDEAD_BEEF);
    check_eq("sw_lat_const", 32'(last_lat), 32'd2);
    check_eq("sw_nrd_const", 32'(last_nrd), 32'd0);
    preset(5, 32'h8899_AABB);
    run_req(0, 2'd1, 0, 15'h0015, 32'h0);
`ifdef MISALIGN_CHECK_EN
    check_eq("lh_mis_err", 32'(last_err), 32'd1);
    check_eq("lh_mis_lat", 32'(last_lat), 32'd1);
`else
    check_eq("lh_mis_data", last_rdata, 32'hFFFF_AABB);
`endif
    run_req(0, 2'd3, 0, 15'h0014, 32'h0);
    check_eq("rsvd_err", 32'(last_err), 32'd1);
    check_eq("rsvd_lat", 32'(last_lat), 32'd1);

    // Reset during RD must drop mem_read without waiting for a clock edge.
    @(negedge clk);
    req_bus.req_valid = 1'b1; req_bus.req_we = 1'b1; req_bus.req_size = 2'd0;
    req_bus.req_addr = 15'h0014; req_bus.req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    check_eq("rd_strobe_pre", 32'(mbus.mem_read), 32'd1);
    #2 rst = 1'b1;
    #1 reset_outputs_zero("rst_rd");
    @(negedge clk) rst = 1'b0;

    // Reset during WAIT of sb must block the write entirely.
    @(negedge clk);
    req_bus.req_valid = 1'b1; req_bus.req_we = 1'b1; req_bus.req_size = 2'd0;
    req_bus.req_addr = 15'h0014; req_bus.req_wdata = 32'h0000_0011;
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_outputs_zero("rst_wait");
    nwr_seen = 0;
    repeat (2) begin @(negedge clk); if (mbus.mem_write) nwr_seen++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (mbus.mem_write) nwr_seen++; end
    check_eq("rst_wait_nwr", 32'(nwr_seen), 32'd0);
    check_eq("rst_wait_ready", 32'(req_bus.req_ready), 32'd1);
    check_eq("rst_wait_word", mem_arr[5], 32'h8899_AABB);

    for (int i = 0; i < 300; i++)
      run_req(1'($urandom), 2'($urandom), 1'($urandom),
              (AW+2)'($urandom_range(0, 63)), $urandom);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
